// File: rtl/cpu_pkg.sv
// Shared fetch front-end constants.
// PC step, default NOP encoding and queue pointer sizing.
package cpu_pkg;

  localparam int          PC_STEP      = 4;
  localparam logic [31:0] NOP_INST_DEF = 32'h0;
  localparam int          DEPTH_DEF    = 4;
  localparam int          PTR_W_DEF    = $clog2(DEPTH_DEF);

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_queue_mem.sv
// Queue storage: one write port, one async read port.
// Data is never reset; validity is tracked by the pointers.
module prefetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             Clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front-end: PC register feeding a
// circular queue of {pc4, inst} pairs consumed by ID.
module inst_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP_INST = NOP_INST_DEF,
  localparam int              PTR_W    = ptr_w(DEPTH),
  localparam int              CNT_W    = PTR_W + 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  output logic [WIDTH-1:0] fetch_pc,
  input  logic [WIDTH-1:0] fetch_inst,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_inst,
  output logic [WIDTH-1:0] out_pc4,
  input  logic             out_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   pc_next;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [2*WIDTH-1:0] head;
  logic               full;
  logic               pop;
  logic               push;

  assign pc_next = pc + WIDTH'(PC_STEP);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop     = out_valid & out_ready;
  assign push    = ~redirect_valid & (~full | pop);

  prefetch_queue_mem #(
    .W     (2 * WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .Clock (Clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({pc_next, fetch_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Redirect discards wrong-path fetch and any queued entries.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc_next;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign fetch_pc  = pc;
  assign out_valid = (count != '0);
  assign out_inst  = out_valid ? head[WIDTH-1:0] : NOP_INST;
  assign out_pc4   = out_valid ? head[2*WIDTH-1:WIDTH] : '0;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: DEPTH=4 and DEPTH=8 copies
// checked against a queue-based reference model.
module tb_inst_prefetch_queue;

  logic        Clock;
  logic        Resetn;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] fpc_a, finst_a, inst_a, pc4_a;
  logic [31:0] fpc_b, finst_b, inst_b, pc4_b;
  logic        val_a, val_b;
  logic [2:0]  cnt_a;
  logic [3:0]  cnt_b;

  int n_chk;
  int n_pass;

  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [31:0] pca, pcb;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  assign finst_a = rom(fpc_a);
  assign finst_b = rom(fpc_b);

  inst_prefetch_queue #(.WIDTH(32), .DEPTH(4)) dut_a (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .fetch_pc       (fpc_a),
    .fetch_inst     (finst_a),
    .out_valid      (val_a),
    .out_inst       (inst_a),
    .out_pc4        (pc4_a),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .count          (cnt_a)
  );

  inst_prefetch_queue #(.WIDTH(32), .DEPTH(8)) dut_b (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .fetch_pc       (fpc_b),
    .fetch_inst     (finst_b),
    .out_valid      (val_b),
    .out_inst       (inst_b),
    .out_pc4        (pc4_b),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .count          (cnt_b)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    pca = 32'h0;
    pcb = 32'h0;
  endtask

  // Reference: pop if non-empty and ready, then either flush
  // on redirect or fetch one instruction when there is room.
  task automatic model_step();
    if (qa.size() != 0 && out_ready) void'(qa.pop_front());
    if (qb.size() != 0 && out_ready) void'(qb.pop_front());
    if (redirect_valid) begin
      qa.delete();
      qb.delete();
      pca = redirect_pc;
      pcb = redirect_pc;
    end else begin
      if (qa.size() < 4) begin
        qa.push_back({pca + 32'd4, rom(pca)});
        pca = pca + 32'd4;
      end
      if (qb.size() < 8) begin
        qb.push_back({pcb + 32'd4, rom(pcb)});
        pcb = pcb + 32'd4;
      end
    end
  endtask

  task automatic compare_model();
    logic [63:0] ha, hb;
    ha = (qa.size() != 0) ? qa[0] : 64'h0;
    hb = (qb.size() != 0) ? qb[0] : 64'h0;
    chk("a_valid", 64'(val_a), 64'(qa.size() != 0));
    chk("a_inst",  64'(inst_a), 64'(ha[31:0]));
    chk("a_pc4",   64'(pc4_a), 64'(ha[63:32]));
    chk("a_count", 64'(cnt_a), 64'(qa.size()));
    chk("a_fpc",   64'(fpc_a), 64'(pca));
    chk("b_valid", 64'(val_b), 64'(qb.size() != 0));
    chk("b_inst",  64'(inst_b), 64'(hb[31:0]));
    chk("b_pc4",   64'(pc4_b), 64'(hb[63:32]));
    chk("b_count", 64'(cnt_b), 64'(qb.size()));
    chk("b_fpc",   64'(fpc_b), 64'(pcb));
    chk("b_cnt_max", 64'(cnt_b <= 4'd8), 64'h1);
  endtask

  task automatic step();
    model_step();
    @(posedge Clock);
    #2;
    compare_model();
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_valid"}, 64'(val_a), 64'h0);
    chk({tag, "_inst"},  64'(inst_a), 64'h0);
    chk({tag, "_pc4"},   64'(pc4_a), 64'h0);
    chk({tag, "_fpc"},   64'(fpc_a), 64'h0);
    chk({tag, "_count"}, 64'(cnt_a), 64'h0);
    chk({tag, "_bcount"}, 64'(cnt_b), 64'h0);
  endtask

  task automatic do_reset(input string tag);
    Resetn = 1'b0;
    model_clear();
    #1;
    check_reset_outs(tag);
    Resetn = 1'b1;
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    do_reset("rst");

    // Continuous ready: head walks 1,2,3,... with pc4 4,8,12,...
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_inst", 64'(inst_a), 64'(k));
      chk("t1_pc4",  64'(pc4_a), 64'(4 * k));
    end

    // Stall: queue saturates and fetch_pc holds.
    #1;
    do_reset("rst2");
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("t2_count", 64'(cnt_a), 64'd4);
    chk("t2_fpc",   64'(fpc_a), 64'h10);
    chk("t2_bcount", 64'(cnt_b), 64'd8);
    chk("t2_bfpc",  64'(fpc_b), 64'h20);

    // Full queue, one pop: one push as well.
    out_ready = 1'b1;
    step();
    chk("t3_count", 64'(cnt_a), 64'd4);
    chk("t3_fpc",   64'(fpc_a), 64'h14);
    chk("t3_inst",  64'(inst_a), 64'd2);
    out_ready = 1'b0;
    step();

    // Drain in order.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    // Redirect with 3 queued and a pop in the same cycle.
    #1;
    do_reset("rst3");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t4_pre", 64'(cnt_a), 64'd3);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    chk("t4_count", 64'(cnt_a), 64'd0);
    chk("t4_valid", 64'(val_a), 64'd0);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    step();
    chk("t4_inst", 64'(inst_a), 64'h11);
    chk("t4_pc4",  64'(pc4_a), 64'h44);

    // Async reset mid-cycle with two entries queued.
    step();
    chk("t5_pre", 64'(cnt_a), 64'd2);
    #1;
    do_reset("t5");

    // PC wrap past the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // Random ready and redirect.
    for (int k = 0; k < 10000; k++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) out_ready = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
